// File: rtl/tile_window_loader.sv
// tile_window_loader: buffers a 20x20 tile, then streams 3x3 windows.
// Define BORDER_REPLICATE_EN to scan all 400 centres with edge clamping.
module tile_window_loader #(
  parameter int PIX_W = 5,
  parameter int TILE  = 20,
  parameter int LANES = 5,
  parameter int BEATS = 80
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [PIX_W-1:0]   pixel_in0,
  input  logic [PIX_W-1:0]   pixel_in1,
  input  logic [PIX_W-1:0]   pixel_in2,
  input  logic [PIX_W-1:0]   pixel_in3,
  input  logic [PIX_W-1:0]   pixel_in4,
  input  logic               in_valid,
  output logic               in_ready,
  output logic               load_end,
  output logic [9*PIX_W-1:0] win_data,
  output logic               win_valid,
  input  logic               win_ready,
  output logic [4:0]         win_row,
  output logic [4:0]         win_col,
  output logic               tile_done
);

  localparam int CW = $clog2(TILE);
  localparam int AW = $clog2(TILE * TILE);
  localparam int BW = $clog2(BEATS);
`ifdef BORDER_REPLICATE_EN
  localparam int LAST = TILE - 1;
`else
  localparam int LAST = TILE - 3;
`endif

  typedef enum logic [1:0] {LOAD, SCAN, DONE} state_t;

  state_t           state_q, state_d;
  logic [BW-1:0]    beat_q;
  logic [CW-1:0]    r_q, c_q;
  logic             load_end_q;
  logic             capture, accept;
  logic             last_beat, last_win;
  logic [AW-1:0]    base;
  logic [PIX_W-1:0] lane [5];
  logic [PIX_W-1:0] buf_q [TILE*TILE];

  assign lane[0] = pixel_in0;
  assign lane[1] = pixel_in1;
  assign lane[2] = pixel_in2;
  assign lane[3] = pixel_in3;
  assign lane[4] = pixel_in4;

  assign last_beat = beat_q == BW'(BEATS - 1);
  assign last_win  = (r_q == CW'(LAST)) && (c_q == CW'(LAST));
  // row b/4, col (b%4)*LANES+k flattens to b*LANES+k
  assign base      = AW'(beat_q) * AW'(LANES);

  always_ff @(posedge clk) begin
    if (!reset) state_q <= LOAD;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    win_valid = 1'b0;
    tile_done = 1'b0;
    capture   = 1'b0;
    accept    = 1'b0;
    unique case (state_q)
      LOAD: begin
        in_ready = 1'b1;
        capture  = in_valid;
        if (in_valid && last_beat) state_d = SCAN;
      end
      SCAN: begin
        win_valid = 1'b1;
        accept    = win_ready;
        if (win_ready && last_win) state_d = DONE;
      end
      DONE: begin
        tile_done = 1'b1;
        state_d   = LOAD;
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      beat_q     <= '0;
      r_q        <= '0;
      c_q        <= '0;
      load_end_q <= 1'b0;
    end else begin
      load_end_q <= capture && last_beat;
      if (capture)        beat_q <= last_beat ? '0 : beat_q + 1'b1;
      else if (tile_done) beat_q <= '0;
      if (capture && last_beat) begin
        r_q <= '0;
        c_q <= '0;
      end else if (accept) begin
        if (c_q == CW'(LAST)) begin
          c_q <= '0;
          r_q <= last_win ? '0 : r_q + 1'b1;
        end else begin
          c_q <= c_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset && capture)
      for (int k = 0; k < LANES; k++)
        buf_q[base + AW'(k)] <= lane[k];
  end

  function automatic logic [CW-1:0] nb(input logic [CW-1:0] ctr,
                                       input logic [1:0]    d);
`ifdef BORDER_REPLICATE_EN
    if (ctr == '0 && d == 2'd0) return '0;
    if (ctr == CW'(TILE - 1) && d == 2'd2) return CW'(TILE - 1);
    return ctr + CW'(d) - CW'(1);
`else
    return ctr + CW'(d);
`endif
  endfunction

  function automatic logic [AW-1:0] addr(input logic [CW-1:0] ri,
                                         input logic [CW-1:0] ci);
    return AW'(ri) * AW'(TILE) + AW'(ci);
  endfunction

  always_comb begin
    win_data = '0;
    if (state_q == SCAN)
      for (int dr = 0; dr < 3; dr++)
        for (int dc = 0; dc < 3; dc++)
          win_data[PIX_W*(3*dr+dc) +: PIX_W] =
            buf_q[addr(nb(r_q, 2'(dr)), nb(c_q, 2'(dc)))];
  end

  assign load_end = load_end_q;
  assign win_row  = (state_q == SCAN) ? 5'(r_q) : 5'd0;
  assign win_col  = (state_q == SCAN) ? 5'(c_q) : 5'd0;

endmodule

// File: doc/tile_window_loader.md
Name: tile_window_loader

Overview:
- Front-end stage of the edge-detection CHIP, directly upstream of the Gaussian/gradient pipeline.
- Captures one 20x20 tile of 5-bit pixels, delivered on five parallel lanes over 80 beats, into an internal buffer.
- Then streams the 18x18 interior positions in raster order as 3x3 windows over a valid/ready handshake.
- Loads and scans alternate per tile, matching the CHIP's load_end/readable tile cadence.

Parameters:
- PIX_W, 5, pixel bit width
- TILE, 20, tile edge length in pixels
- LANES, 5, pixels delivered per input beat
- BEATS, 80, input beats per tile (TILE*TILE/LANES)

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-low reset
- pixel_in0..pixel_in4  input  5 each  lane pixels for the current beat
- in_valid  input  1  beat qualifier
- in_ready  output  1  high only in LOAD
- load_end  output  1  one-cycle pulse when beat 79 is captured
- win_data  output  45  3x3 window; pixel at offset (dr,dc) in bits [5*(3*dr+dc) +: 5]
- win_valid  output  1  window present
- win_ready  input  1  downstream accept
- win_row  output  5  window centre row minus 1 (0..17)
- win_col  output  5  window centre column minus 1 (0..17)
- tile_done  output  1  one-cycle pulse after the last window is accepted

Behaviour:
- Input mapping: beat b (0..79) writes row b/4, column (b%4)*5+lane, with lane k taken from pixel_in{k}.
- Beat b is captured on a rising edge when in_ready && in_valid.
- States:
  - LOAD: beat counter 0..79. When beat 79 is captured: load_end=1 for that next cycle, state to SCAN, r=c=0.
  - SCAN: win_valid=1. win_data is combinational from the buffer at rows r..r+2, columns c..c+2. On win_valid && win_ready: c++; when c==17, c=0 and r++. Accepting (17,17) moves the state to DONE.
  - DONE: one cycle. tile_done=1, beat counter=0, next state LOAD.
- Latency: window (0,0) is valid in the cycle immediately after the beat-79 capture edge. With win_ready held high, 324 windows take 324 consecutive cycles, then 1 DONE cycle. The next load can start 2 cycles after the last window is accepted.
- Backpressure: win_ready low holds r, c and win_data stable. win_valid never drops mid-tile.
- in_valid gaps during LOAD stall the beat counter; no beat is skipped.
- in_valid during SCAN/DONE is ignored: in_ready=0, buffer is not written.
- win_row/win_col equal r/c in SCAN and are 0 otherwise.
- Reset (reset==0 at an edge), including mid-LOAD or mid-SCAN:
  - state LOAD, beat counter 0, r=c=0.
  - Outputs: in_ready=1, load_end=0, win_valid=0, tile_done=0, win_row=win_col=0, win_data=0 (gated while not SCAN).
  - Buffer contents are not cleared; the next tile overwrites every location before use.
- All counters are unsigned. No wrap-around is possible; the state transitions bound them.

Optional Feature:
- Macro BORDER_REPLICATE_EN.
- Defined:
  - SCAN covers all 20x20 centres (r,c = 0..19). win_row/win_col give the centre directly.
  - Out-of-tile neighbours are replaced by the nearest edge pixel (clamp index to 0..19).
  - Window count is 400; the DONE transition happens on accepting (19,19).
- Undefined: 18x18 interior behaviour exactly as above, 324 windows.

Test Plan:
- Ramp tile (pixel(row,col)=(row+col)%32), in_valid always 1, win_ready always 1:
  - load_end pulses after beat 79.
  - 324 windows in consecutive cycles; window (0,0) centre = 2; window (17,17) bit field [0+:5] = 2.
  - tile_done pulses after (17,17), then in_ready=1.
- in_valid low for 3 cycles at beat 40: beat counter holds; tile contents identical to the gap-free run; load_end delayed by exactly 3 cycles.
- win_ready low for 5 cycles at window (3,7): win_row=3, win_col=7 and win_data stable throughout; the next accepted window is (3,8); total windows 324.
- Reset asserted at window (9,0) with a second tile driven afterwards: win_valid=0 the cycle after reset; full reload required; second tile's windows match its own golden data, not the stale buffer.
- in_valid=1 with new pixel values during SCAN: buffer unchanged, every remaining window equals the first tile's golden data.
- With BORDER_REPLICATE_EN: window (0,0) on the ramp tile has all of rows 0..1 / columns 0..1 replicated (bits [0+:5]=0); 400 windows, then tile_done.
